// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half-adder cells; the serial adder's bit slice.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    // Both half-adder carries can never be high together, so OR gives the majority.
    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// with a start/done handshake and registered sum/cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             s_bit;
    logic             carry_next;

    full_adder u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (s_bit),
        .co (carry_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        count  <= '0;
                        sum_sr <= '0;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
                    carry  <= carry_next;
                    count  <= count + 1'b1;
                    // Last bit: publish the completed word directly, bypassing sum_sr.
                    if (count == LAST) begin
                        sum   <= {s_bit, sum_sr[WIDTH-1:1]};
                        cout  <= carry_next;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, plus a WIDTH=2 instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one add, count edges until done (bounded), then step back to IDLE.
    task automatic do_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          output int edges, output logic [7:0] s, output logic c);
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
        s = sum;
        c = cout;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; a = 0; b = 0; cin = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e; logic [7:0] s; logic c;
        do_add(8'h3C, 8'h05, 1'b0, e, s, c);
        tests++;
        if (e !== 8) begin
            failed++; $display("FAIL basic_latency: edges=%0d want 8", e);
        end
        tests++;
        if (s !== 8'h41 || c !== 1'b0) begin
            failed++; $display("FAIL basic_sum: sum=%h cout=%b want 41 0", s, c);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failed++; $display("FAIL basic_after: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_ignore();
        int dones = 0;
        int held_bad = 0;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b1) begin
            failed++; $display("FAIL ignore_busy_rise: busy=%b want 1", busy);
        end
        for (int i = 1; i <= 8; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            tick();
            if (done) dones++;
            if (i < 8 && sum !== 8'h41) held_bad++;
        end
        tests++;
        if (held_bad != 0) begin
            failed++; $display("FAIL ignore_sum_held: %0d cycles with sum changed, want 0", held_bad);
        end
        tests++;
        if (done !== 1'b1 || sum !== 8'h46 || cout !== 1'b0) begin
            failed++; $display("FAIL ignore_result: done=%b sum=%h cout=%b want 1 46 0", done, sum, cout);
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        tests++;
        if (dones != 1 || busy !== 1'b0) begin
            failed++; $display("FAIL ignore_single_op: dones=%0d busy=%b want 1 0", dones, busy);
        end
    endtask

    task automatic test_overflow();
        int e; logic [7:0] s; logic c;
        do_add(8'hFF, 8'h01, 1'b0, e, s, c);
        tests++;
        if (s !== 8'h00 || c !== 1'b1) begin
            failed++; $display("FAIL ovf_ff_01: sum=%h cout=%b want 00 1", s, c);
        end
        do_add(8'hFF, 8'h00, 1'b1, e, s, c);
        tests++;
        if (s !== 8'h00 || c !== 1'b1) begin
            failed++; $display("FAIL ovf_ff_cin: sum=%h cout=%b want 00 1", s, c);
        end
        do_add(8'h3C, 8'h05, 1'b1, e, s, c);
        tests++;
        if (s !== 8'h42 || c !== 1'b0) begin
            failed++; $display("FAIL cin_add: sum=%h cout=%b want 42 0", s, c);
        end
    endtask

    task automatic test_mid_reset();
        int e; int dones = 0; logic [7:0] s; logic c;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            failed++;
            $display("FAIL midreset_clear: busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        tests++;
        if (dones != 0 || sum !== 8'h00) begin
            failed++; $display("FAIL midreset_no_done: dones=%0d sum=%h want 0 00", dones, sum);
        end
        do_add(8'h01, 8'h01, 1'b0, e, s, c);
        tests++;
        if (s !== 8'h02 || c !== 1'b0 || e !== 8) begin
            failed++; $display("FAIL midreset_next: sum=%h cout=%b edges=%0d want 02 0 8", s, c, e);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0; int last = -1; int gap_bad = 0; int val_bad = 0;
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                dones++;
                if (sum !== 8'h00 || cout !== 1'b1) val_bad++;
                if (last >= 0 && i - last != 10) gap_bad++;
                last = i;
            end
        end
        start = 1'b0;
        repeat (14) tick();
        tests++;
        if (dones != 4 || gap_bad != 0) begin
            failed++; $display("FAIL b2b_rate: dones=%0d bad_gaps=%0d want 4 0", dones, gap_bad);
        end
        tests++;
        if (val_bad != 0) begin
            failed++; $display("FAIL b2b_result: %0d bad results want 0", val_bad);
        end
    endtask

    task automatic test_random();
        int e; logic [7:0] s; logic c; logic [7:0] ra, rb; logic rc; logic [8:0] exp;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            do_add(ra, rb, rc, e, s, c);
            tests++;
            if ({c, s} !== exp || e !== 8) begin
                failed++;
                $display("FAIL random_%0d: %h+%h+%b got cout,sum=%h edges=%0d want %h edges 8",
                         i, ra, rb, rc, {c, s}, e, exp);
            end
        end
    endtask

    task automatic test_width2();
        int e = 0;
        a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        while (!done2 && e < 10) begin
            tick();
            e++;
        end
        tests++;
        if (e !== 2 || sum2 !== 2'b11 || cout2 !== 1'b1) begin
            failed++; $display("FAIL width2: edges=%0d sum=%b cout=%b want 2 11 1", e, sum2, cout2);
        end
        tick();
        tests++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            failed++; $display("FAIL width2_after: busy=%b done=%b want 0 0", busy2, done2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        test_random();
        test_width2();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
